alarm_ctrl: RTL and testbench

Alarm controller for the digital clock. It holds the alarm time (HH:MM), sequences the alarm edit, arm, ring and snooze behaviour, and watches the running time from the time-holder. It drives a display-select and an edit flag, so top can route the shared up/down pulses and HEX digits to either the time-holder or the alarm registers. It sits beside the time-holder, fed by the same synchronized, edge-detected key pulses and tick_sec.

---
 rtl/alarm_pkg.sv | 19 +
 rtl/mod_updown_cnt.sv | 25 ++
 rtl/alarm_ctrl.sv | 141 ++++++++++++++
 tb/tb_alarm_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm controller.
package alarm_pkg;

    localparam int HR_MAX  = 23;
    localparam int MIN_MAX = 59;
    localparam int HR_W    = 5;
    localparam int MIN_W   = 6;

    // Encoding is visible on LEDR, so the values are fixed.
    typedef enum logic [2:0] {
        DISARMED = 3'd0,
        SET_HR   = 3'd1,
        SET_MIN  = 3'd2,
        ARMED    = 3'd3,
        RINGING  = 3'd4,
        SNOOZE   = 3'd5
    } alarm_state_t;

endpackage

// File: rtl/mod_updown_cnt.sv
// Modular up/down register: reset loads INIT, inc/dec wrap over 0..MAX.
module mod_updown_cnt #(
    parameter int MAX  = 23,
    parameter int W    = 5,
    parameter int INIT = 0
) (
    input  logic         CLOCK_50,
    input  logic         reset,
    input  logic         en,
    input  logic         up,
    input  logic         down,
    output logic [W-1:0] q
);

    // up and down together cancel; otherwise step with wrap-around.
    always_ff @(posedge CLOCK_50) begin
        if (reset)
            q <= W'(INIT);
        else if (en && up && !down)
            q <= (q == W'(MAX)) ? '0 : q + W'(1);
        else if (en && down && !up)
            q <= (q == '0) ? W'(MAX) : q - W'(1);
    end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm controller: alarm time storage, edit/arm/ring/snooze sequencing.
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int ALM_H_INIT = 6,
    parameter int ALM_M_INIT = 0,
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300,
    parameter int MAX_SNOOZE = 3
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             tick_sec,
    input  logic             alm_pressed,
    input  logic             up_pressed,
    input  logic             down_pressed,
    input  logic             dismiss_pressed,
    input  logic [5:0]       seconds,
    input  logic [MIN_W-1:0] minutes,
    input  logic [HR_W-1:0]  hours,
    output logic [HR_W-1:0]  alarm_hours,
    output logic [MIN_W-1:0] alarm_minutes,
    output logic [2:0]       alarm_state,
    output logic             edit_active,
    output logic             disp_sel,
    output logic             ring,
    output logic             ring_blink
);

    localparam logic [7:0] RING_LD   = 8'(RING_SEC);
    localparam logic [9:0] SNOOZE_LD = 10'(SNOOZE_SEC);
    localparam logic [2:0] SN_MAX    = 3'(MAX_SNOOZE);

    alarm_state_t state, state_n;
    logic [7:0]   ring_cnt, ring_cnt_n;
    logic [9:0]   snooze_cnt, snooze_cnt_n;
    logic [2:0]   snooze_used, snooze_used_n;
    logic         blink_n;
    logic         match, match_d;

    // Alarm-mode key outranks up/down, so an edit step is dropped when both arrive.
    mod_updown_cnt #(.MAX(HR_MAX), .W(HR_W), .INIT(ALM_H_INIT)) u_hr (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .en       (state == SET_HR && !alm_pressed),
        .up       (up_pressed),
        .down     (down_pressed),
        .q        (alarm_hours)
    );

    mod_updown_cnt #(.MAX(MIN_MAX), .W(MIN_W), .INIT(ALM_M_INIT)) u_min (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .en       (state == SET_MIN && !alm_pressed),
        .up       (up_pressed),
        .down     (down_pressed),
        .q        (alarm_minutes)
    );

    assign match = (hours == alarm_hours) && (minutes == alarm_minutes) && (seconds == 6'd0);

    // State, counters and the match history register.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state       <= DISARMED;
            ring_cnt    <= '0;
            snooze_cnt  <= '0;
            snooze_used <= '0;
            ring_blink  <= 1'b0;
            match_d     <= 1'b0;
        end else begin
            state       <= state_n;
            ring_cnt    <= ring_cnt_n;
            snooze_cnt  <= snooze_cnt_n;
            snooze_used <= snooze_used_n;
            ring_blink  <= blink_n;
            match_d     <= match;
        end
    end

    // Next state with priority alm > dismiss > up/down > tick expiry.
    always_comb begin
        state_n       = state;
        ring_cnt_n    = ring_cnt;
        snooze_cnt_n  = snooze_cnt;
        snooze_used_n = snooze_used;
        blink_n       = ring_blink;
        case (state)
            DISARMED: if (alm_pressed) state_n = SET_HR;
            SET_HR:   if (alm_pressed) state_n = SET_MIN;
            SET_MIN:  if (alm_pressed) state_n = ARMED;
            ARMED: begin
                if (alm_pressed)
                    state_n = DISARMED;
                else if (match && !match_d) begin
                    state_n       = RINGING;
                    ring_cnt_n    = RING_LD;
                    snooze_used_n = '0;
                    blink_n       = 1'b0;
                end
            end
            RINGING: begin
                if (alm_pressed)
                    state_n = DISARMED;
                else if (dismiss_pressed)
                    state_n = ARMED;
                else if ((up_pressed || down_pressed) && snooze_used < SN_MAX) begin
                    state_n       = SNOOZE;
                    snooze_cnt_n  = SNOOZE_LD;
                    snooze_used_n = snooze_used + 3'd1;
                end else if (tick_sec) begin
                    ring_cnt_n = (ring_cnt == '0) ? '0 : ring_cnt - 8'd1;
                    blink_n    = ~ring_blink;
                    if (ring_cnt <= 8'd1) state_n = ARMED;
                end
            end
            SNOOZE: begin
                if (alm_pressed)
                    state_n = DISARMED;
                else if (dismiss_pressed)
                    state_n = ARMED;
                else if (tick_sec) begin
                    snooze_cnt_n = (snooze_cnt == '0) ? '0 : snooze_cnt - 10'd1;
                    if (snooze_cnt <= 10'd1) begin
                        state_n    = RINGING;
                        ring_cnt_n = RING_LD;
                    end
                end
            end
            default: state_n = DISARMED;
        endcase
        // Blink only runs while ringing; any other state forces it low.
        if (state_n != RINGING) blink_n = 1'b0;
    end

    assign alarm_state = state;
    assign edit_active = (state == SET_HR) || (state == SET_MIN);
    assign disp_sel    = edit_active;
    assign ring        = (state == RINGING);

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed self-checking bench for alarm_ctrl.
module tb_alarm_ctrl;

    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b1;
    logic       tick_sec = 1'b0, alm_pressed = 1'b0, up_pressed = 1'b0;
    logic       down_pressed = 1'b0, dismiss_pressed = 1'b0;
    logic [5:0] seconds = 6'd5, minutes = 6'd0;
    logic [4:0] hours = 5'd0;
    logic [4:0] alarm_hours;
    logic [5:0] alarm_minutes;
    logic [2:0] alarm_state;
    logic       edit_active, disp_sel, ring, ring_blink;

    int checks = 0;
    int errors = 0;

    alarm_ctrl dut (
        .CLOCK_50        (CLOCK_50),
        .reset           (reset),
        .tick_sec        (tick_sec),
        .alm_pressed     (alm_pressed),
        .up_pressed      (up_pressed),
        .down_pressed    (down_pressed),
        .dismiss_pressed (dismiss_pressed),
        .seconds         (seconds),
        .minutes         (minutes),
        .hours           (hours),
        .alarm_hours     (alarm_hours),
        .alarm_minutes   (alarm_minutes),
        .alarm_state     (alarm_state),
        .edit_active     (edit_active),
        .disp_sel        (disp_sel),
        .ring            (ring),
        .ring_blink      (ring_blink)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic cyc();
        @(posedge CLOCK_50);
        #1;
    endtask

    // One-cycle pulse on any combination of the key/tick inputs.
    task automatic pulse(input logic a, input logic u, input logic d, input logic dis, input logic t);
        alm_pressed = a; up_pressed = u; down_pressed = d; dismiss_pressed = dis; tick_sec = t;
        cyc();
        alm_pressed = 0; up_pressed = 0; down_pressed = 0; dismiss_pressed = 0; tick_sec = 0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) pulse(0, 0, 0, 0, 1);
    endtask

    // Walk seconds off 0 and back so the matching minute produces a fresh edge.
    task automatic retrigger();
        seconds = 6'd1; cyc();
        seconds = 6'd0; cyc();
    endtask

    initial begin
        cyc(); cyc();
        reset = 1'b0;
        chk("rst_state", alarm_state, 0);
        chk("rst_hr", alarm_hours, 6);
        chk("rst_min", alarm_minutes, 0);
        chk("rst_ring", ring, 0);
        chk("rst_blink", ring_blink, 0);
        chk("rst_edit", edit_active, 0);
        chk("rst_disp", disp_sel, 0);

        // Hours edit with wrap in both directions.
        pulse(1, 0, 0, 0, 0);
        chk("sethr_state", alarm_state, 1);
        chk("sethr_edit", edit_active, 1);
        chk("sethr_disp", disp_sel, 1);
        pulse(0, 0, 1, 0, 0);
        chk("hr_down1", alarm_hours, 5);
        for (int i = 0; i < 6; i++) pulse(0, 0, 1, 0, 0);
        chk("hr_wrap_down", alarm_hours, 23);
        pulse(0, 1, 0, 0, 0);
        chk("hr_wrap_up", alarm_hours, 0);
        for (int i = 0; i < 7; i++) pulse(0, 1, 0, 0, 0);
        chk("hr_7", alarm_hours, 7);

        // Minutes edit.
        pulse(1, 0, 0, 0, 0);
        chk("setmin_state", alarm_state, 2);
        pulse(0, 0, 1, 0, 0);
        chk("min_wrap_down", alarm_minutes, 59);
        pulse(0, 1, 0, 0, 0);
        chk("min_wrap_up", alarm_minutes, 0);
        pulse(0, 1, 1, 0, 0);
        chk("min_updown", alarm_minutes, 0);
        for (int i = 0; i < 30; i++) pulse(0, 1, 0, 0, 0);
        chk("min_30", alarm_minutes, 30);
        pulse(1, 0, 0, 0, 0);
        chk("armed_state", alarm_state, 3);
        chk("armed_disp", disp_sel, 0);
        chk("armed_edit", edit_active, 0);

        // Trigger at 07:30:00.
        hours = 5'd7; minutes = 6'd29; seconds = 6'd59; cyc();
        chk("pre_match", alarm_state, 3);
        minutes = 6'd30; seconds = 6'd0; cyc();
        chk("ring_state", alarm_state, 4);
        chk("ring_on", ring, 1);
        chk("ring_blink0", ring_blink, 0);
        chk("ring_cnt_ld", dut.ring_cnt, 60);
        ticks(1);
        chk("blink1", ring_blink, 1);
        chk("ring_cnt59", dut.ring_cnt, 59);
        ticks(1);
        chk("blink2", ring_blink, 0);
        ticks(57);
        chk("ring_cnt1", dut.ring_cnt, 1);
        chk("still_ring", alarm_state, 4);
        ticks(1);
        chk("auto_stop", alarm_state, 3);
        chk("auto_stop_ring", ring, 0);
        chk("auto_stop_blink", ring_blink, 0);
        cyc(); cyc(); cyc();
        chk("no_retrig", alarm_state, 3);

        // Snooze cycles up to the limit.
        retrigger();
        chk("retrig", alarm_state, 4);
        for (int s = 1; s <= 3; s++) begin
            pulse(0, 1, 0, 0, 0);
            chk("snooze_state", alarm_state, 5);
            chk("snooze_ring", ring, 0);
            chk("snooze_used", dut.snooze_used, s);
            chk("snooze_cnt_ld", dut.snooze_cnt, 300);
            ticks(299);
            chk("snooze_cnt1", dut.snooze_cnt, 1);
            chk("snooze_hold", alarm_state, 5);
            ticks(1);
            chk("rering", alarm_state, 4);
            chk("rering_cnt", dut.ring_cnt, 60);
        end
        pulse(0, 0, 1, 0, 0);
        chk("snooze_limit", alarm_state, 4);
        chk("snooze_limit_used", dut.snooze_used, 3);

        // Dismiss beats tick; no retrigger while seconds stays 0.
        pulse(0, 0, 0, 1, 1);
        chk("dismiss", alarm_state, 3);
        cyc(); cyc();
        chk("dismiss_hold", alarm_state, 3);

        // alm in SNOOZE disarms.
        retrigger();
        chk("retrig2_used", dut.snooze_used, 0);
        pulse(0, 1, 0, 0, 0);
        chk("snooze2", alarm_state, 5);
        pulse(1, 0, 0, 0, 0);
        chk("alm_disarm", alarm_state, 0);
        chk("alm_disarm_ring", ring, 0);

        // Edit hours to 12; alm wins over a simultaneous up.
        pulse(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) pulse(0, 1, 0, 0, 0);
        chk("hr_12", alarm_hours, 12);
        pulse(1, 1, 0, 0, 0);
        chk("alm_prio_state", alarm_state, 2);
        chk("alm_prio_hr", alarm_hours, 12);
        pulse(1, 0, 0, 0, 0);
        hours = 5'd12;
        retrigger();
        chk("ring_12", alarm_state, 4);
        pulse(0, 1, 0, 0, 0);
        ticks(3);
        chk("snooze_12", alarm_state, 5);

        // Reset mid-snooze.
        reset = 1'b1; cyc(); reset = 1'b0;
        seconds = 6'd5;
        chk("mid_rst_state", alarm_state, 0);
        chk("mid_rst_hr", alarm_hours, 6);
        chk("mid_rst_min", alarm_minutes, 0);
        chk("mid_rst_ring_cnt", dut.ring_cnt, 0);
        chk("mid_rst_snz_cnt", dut.snooze_cnt, 0);
        chk("mid_rst_snz_used", dut.snooze_used, 0);
        chk("mid_rst_match_d", dut.match_d, 0);
        chk("mid_rst_ring", ring, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
